// File: rtl/score_pkg.sv
// score_pkg: shared sizing helpers and arithmetic for the power-of-two score pipeline.
//   frac_bits  - fractional bits of the exact internal sum
//   pos_w/neg_w - widths of the unsigned positive/negative partial sums
//   sum_w      - signed width of the exact difference
//   zero_pt    - offset-binary zero point of the output byte
//   saturate   - floor to output resolution, add zero point, clamp
//   cls_w      - class index width
package score_pkg;

  typedef logic signed [63:0] wide_t;

  localparam int N_CLASSES_DEF = 10;
  localparam int CLS_W_DEF     = $clog2(N_CLASSES_DEF);
  typedef logic [CLS_W_DEF-1:0] cls_idx_t;

  function automatic int min_exp(input int pos_bot, input int neg_top, input int n_neg);
    int lo_neg;
    lo_neg = neg_top - n_neg + 1;
    return (lo_neg < pos_bot) ? lo_neg : pos_bot;
  endfunction

  function automatic int frac_bits(input int pos_bot, input int neg_top, input int n_neg);
    int m;
    m = min_exp(pos_bot, neg_top, n_neg);
    return (m < 0) ? -m : 0;
  endfunction

  // Bins span shifts lo..lo+n-1 above the LSB, so the sum is < 2^(cnt_w+lo+n).
  function automatic int pos_w(input int cnt_w, input int n_pos, input int pos_bot, input int f);
    return cnt_w + pos_bot + f + n_pos;
  endfunction

  function automatic int neg_w(input int cnt_w, input int neg_top, input int f);
    return cnt_w + neg_top + f + 1;
  endfunction

  function automatic int sum_w(input int pw, input int nw);
    return ((pw > nw) ? pw : nw) + 1;
  endfunction

  function automatic longint zero_pt(input int score_w);
    return longint'(1) <<< (score_w - 1);
  endfunction

  function automatic int cls_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Arithmetic right shift of a signed value is floor toward minus infinity.
  function automatic logic [31:0] saturate(input wide_t sum, input int f_in,
                                           input int frac_out, input int score_w);
    wide_t v;
    wide_t hi;
    if (f_in >= frac_out) v = sum >>> (f_in - frac_out);
    else                  v = sum <<< (frac_out - f_in);
    v  = v + wide_t'(zero_pt(score_w));
    hi = (wide_t'(1) <<< score_w) - wide_t'(1);
    if (v < 0)       return '0;
    else if (v > hi) return 32'(hi);
    else             return 32'(v);
  endfunction

endpackage

// File: rtl/score_argmax.sv
// score_argmax: tracks the highest score over a frame of N_CLASSES output handshakes.
//   hs_i          - output handshake of the pipeline (one class result)
//   clear_i       - frame abort; re-arms the tracker, suppresses the pulse
//   score_i/class_i - handshaked result
//   best_valid_o  - one-cycle pulse after the last class of a frame
//   best_class_o/best_score_o - frame winner, held until the next frame end
module score_argmax #(
  parameter int SCORE_W   = 8,
  parameter int N_CLASSES = 10,
  parameter int CLS_W     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hs_i,
  input  logic               clear_i,
  input  logic [SCORE_W-1:0] score_i,
  input  logic [CLS_W-1:0]   class_i,
  output logic               best_valid_o,
  output logic [CLS_W-1:0]   best_class_o,
  output logic [SCORE_W-1:0] best_score_o
);

  logic [CLS_W-1:0]   cnt_q;
  logic [SCORE_W-1:0] run_score_q, best_score_q;
  logic [CLS_W-1:0]   run_class_q, best_class_q;
  logic               best_valid_q;

  logic               take;
  logic               last;
  logic [SCORE_W-1:0] win_score_d;
  logic [CLS_W-1:0]   win_class_d;

  // Strictly-greater replace keeps the lower index on ties.
  always_comb begin
    take        = (cnt_q == '0) || (score_i > run_score_q);
    last        = (cnt_q == CLS_W'(N_CLASSES - 1));
    win_score_d = take ? score_i : run_score_q;
    win_class_d = take ? class_i : run_class_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      run_score_q  <= '0;
      run_class_q  <= '0;
      best_score_q <= '0;
      best_class_q <= '0;
      best_valid_q <= 1'b0;
    end else begin
      best_valid_q <= 1'b0;
      if (clear_i) begin
        cnt_q <= '0;
      end else if (hs_i) begin
        run_score_q <= win_score_d;
        run_class_q <= win_class_d;
        if (last) begin
          cnt_q        <= '0;
          best_score_q <= win_score_d;
          best_class_q <= win_class_d;
          best_valid_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CLS_W'(1);
        end
      end
    end
  end

  assign best_valid_o = best_valid_q;
  assign best_class_o = best_class_q;
  assign best_score_o = best_score_q;

endmodule

// File: rtl/pow2_score_pipe.sv
// pow2_score_pipe: per-class score from power-of-two weighted bin counts.
//   in_valid/in_ready, in_neg, in_pos - one class histogram per beat
//   in_clear      - synchronous frame abort (pipeline flushed, counters reset)
//   out_valid/out_ready, out_score, out_class - saturated offset-binary score
//   best_valid, best_class, best_score - frame arg-max from score_argmax
// Three register stages: partial sums, saturated score, output register.
module pow2_score_pipe
  import score_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int N_NEG       = 5,
  parameter int N_POS       = 8,
  parameter int NEG_TOP_EXP = -2,
  parameter int POS_BOT_EXP = -6,
  parameter int FRAC_BITS   = 2,
  parameter int SCORE_W     = 8,
  parameter int N_CLASSES   = 10,
  localparam int CLS_W      = cls_w(N_CLASSES)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [N_NEG-1:0][CNT_W-1:0] in_neg,
  input  logic [N_POS-1:0][CNT_W-1:0] in_pos,
  input  logic                        in_clear,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [SCORE_W-1:0]          out_score,
  output logic [CLS_W-1:0]            out_class,
  output logic                        best_valid,
  output logic [CLS_W-1:0]            best_class,
  output logic [SCORE_W-1:0]          best_score
);

  localparam int F  = frac_bits(POS_BOT_EXP, NEG_TOP_EXP, N_NEG);
  localparam int PW = pos_w(CNT_W, N_POS, POS_BOT_EXP, F);
  localparam int NW = neg_w(CNT_W, NEG_TOP_EXP, F);
  localparam int SW = sum_w(PW, NW);

  logic               rdy_q;
  logic               en;
  logic               accept;

  logic [PW-1:0]      pos_sum_d, pos_sum_q;
  logic [NW-1:0]      neg_sum_d, neg_sum_q;
  logic signed [SW-1:0] diff;
  logic [SCORE_W-1:0] score_d, score_q, out_score_q;

  logic               v1_q, v2_q, out_valid_q;
  logic [CLS_W-1:0]   cls_cnt_q, cls1_q, cls2_q, out_class_q;

  // rdy_q keeps in_ready low while reset is asserted.
  assign en       = !out_valid_q || out_ready;
  assign in_ready = rdy_q && en && !in_clear;
  assign accept   = in_valid && in_ready;

  // Every bin lands on an integer shift because F covers the smallest exponent.
  always_comb begin
    pos_sum_d = '0;
    for (int j = 0; j < N_POS; j++) begin
      pos_sum_d = pos_sum_d + (PW'(in_pos[j]) << (POS_BOT_EXP + F + j));
    end
    neg_sum_d = '0;
    for (int i = 0; i < N_NEG; i++) begin
      neg_sum_d = neg_sum_d + (NW'(in_neg[i]) << (NEG_TOP_EXP + F - i));
    end
  end

  always_comb begin
    diff    = $signed(SW'(pos_sum_q)) - $signed(SW'(neg_sum_q));
    score_d = SCORE_W'(saturate(wide_t'(diff), F, FRAC_BITS, SCORE_W));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q       <= 1'b0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      cls_cnt_q   <= '0;
      cls1_q      <= '0;
      cls2_q      <= '0;
      out_class_q <= '0;
      pos_sum_q   <= '0;
      neg_sum_q   <= '0;
      score_q     <= '0;
      out_score_q <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (in_clear) begin
        v1_q        <= 1'b0;
        v2_q        <= 1'b0;
        out_valid_q <= 1'b0;
        cls_cnt_q   <= '0;
      end else if (en) begin
        v1_q        <= accept;
        v2_q        <= v1_q;
        out_valid_q <= v2_q;
        if (accept) begin
          cls_cnt_q <= (cls_cnt_q == CLS_W'(N_CLASSES - 1)) ? '0 : cls_cnt_q + CLS_W'(1);
        end
      end
      if (en) begin
        pos_sum_q   <= pos_sum_d;
        neg_sum_q   <= neg_sum_d;
        cls1_q      <= cls_cnt_q;
        score_q     <= score_d;
        cls2_q      <= cls1_q;
        out_score_q <= score_q;
        out_class_q <= cls2_q;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_score = out_score_q;
  assign out_class = out_class_q;

  score_argmax #(
    .SCORE_W  (SCORE_W),
    .N_CLASSES(N_CLASSES),
    .CLS_W    (CLS_W)
  ) u_argmax (
    .clk         (clk),
    .rst_n       (rst_n),
    .hs_i        (out_valid_q && out_ready),
    .clear_i     (in_clear),
    .score_i     (out_score_q),
    .class_i     (out_class_q),
    .best_valid_o(best_valid),
    .best_class_o(best_class),
    .best_score_o(best_score)
  );

endmodule

// File: tb/tb_pow2_score_pipe.sv
module tb_pow2_score_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0][7:0] in_neg;
  logic [7:0][7:0] in_pos;
  logic        in_clear;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_score;
  logic [3:0]  out_class;
  logic        best_valid;
  logic [3:0]  best_class;
  logic [7:0]  best_score;

  pow2_score_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_neg    (in_neg),
    .in_pos    (in_pos),
    .in_clear  (in_clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_score (out_score),
    .out_class (out_class),
    .best_valid(best_valid),
    .best_class(best_class),
    .best_score(best_score)
  );

  always #5 clk = ~clk;

  typedef struct {
    int score;
    int cls;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   n_pulse = 0;
  int   exp_cls = 0;
  bit   rnd_rdy = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Independent reference: sum in units of 2^-6, floor to 2^-2 is >>> 4.
  function automatic int model_score(input logic [39:0] n, input logic [63:0] p);
    longint s;
    longint v;
    s = 0;
    for (int j = 0; j < 8; j++) s += longint'(p[j*8 +: 8]) << j;
    for (int i = 0; i < 5; i++) s -= longint'(n[i*8 +: 8]) << (4 - i);
    v = (s >>> 4) + 128;
    if (v < 0) v = 0;
    if (v > 255) v = 255;
    return int'(v);
  endfunction

  // out_ready driver
  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor, scoreboard and arg-max reference.
  initial begin
    bit   exp_bv = 0;
    int   exp_bc = 0, exp_bs = 0;
    int   m_cnt = 0, m_bc = 0, m_bs = 0;
    bit   stall_prev = 0;
    int   sv_score = 0, sv_class = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        exp_bv = 0; m_cnt = 0; stall_prev = 0;
      end else begin
        chk("best_valid", best_valid, exp_bv);
        if (exp_bv) begin
          n_pulse++;
          chk("best_class", best_class, exp_bc);
          chk("best_score", best_score, exp_bs);
        end
        exp_bv = 0;
        if (stall_prev) begin
          chk("stall_valid", out_valid, 1);
          chk("stall_score", out_score, sv_score);
          chk("stall_class", out_class, sv_class);
        end
        stall_prev = out_valid && !out_ready && !in_clear;
        sv_score = out_score;
        sv_class = out_class;
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            chk("spurious_out", 1, 0);
          end else begin
            e = q.pop_front();
            chk("out_score", out_score, e.score);
            chk("out_class", out_class, e.cls);
            if (m_cnt == 0 || e.score > m_bs) begin
              m_bs = e.score;
              m_bc = e.cls;
            end
            if (m_cnt == 9) begin
              exp_bv = !in_clear;
              exp_bc = m_bc;
              exp_bs = m_bs;
              m_cnt = 0;
            end else begin
              m_cnt++;
            end
          end
        end
        if (in_clear) begin
          q.delete();
          m_cnt = 0;
          exp_bv = 0;
        end
      end
    end
  end

  task automatic push_exp(input int score);
    exp_t e;
    e.score = score;
    e.cls   = exp_cls;
    q.push_back(e);
    exp_cls = (exp_cls == 9) ? 0 : exp_cls + 1;
  endtask

  task automatic send(input logic [39:0] n, input logic [63:0] p, input int exp);
    bit done;
    done = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_neg   = n;
    in_pos   = p;
    for (int k = 0; k < 200 && !done; k++) begin
      #1;
      if (in_ready) begin
        push_exp(exp);
        done = 1;
      end
      @(posedge clk);
      if (!done) @(negedge clk);
    end
    if (!done) chk("accept_timeout", 0, 1);
  endtask

  task automatic send_rand();
    logic [39:0] n;
    logic [63:0] p;
    for (int i = 0; i < 5; i++) n[i*8 +: 8] = 8'($urandom_range(0, 15));
    for (int j = 0; j < 8; j++) p[j*8 +: 8] = 8'($urandom_range(0, 6));
    send(n, p, model_score(n, p));
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic clear_frame(input bit with_valid);
    @(negedge clk);
    in_clear = 1'b1;
    in_valid = with_valid;
    #1;
    chk("ready_in_clear", in_ready, 0);
    exp_cls = 0;
    @(negedge clk);
    in_clear = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && q.size() > 0; i++) @(negedge clk);
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_clear = 1'b0;
    in_neg   = '0;
    in_pos   = '0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_score", out_score, 0);
    chk("rst_out_class", out_class, 0);
    chk("rst_best_valid", best_valid, 0);
    chk("rst_best_class", best_class, 0);
    chk("rst_best_score", best_score, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #2;
    chk("ready_after_rst", in_ready, 1);

    // Latency: accepted on edge 1, visible after edge 3.
    @(negedge clk);
    in_valid = 1'b1;
    in_neg   = '0;
    in_pos   = '0;
    #1;
    chk("lat_accept", in_ready, 1);
    push_exp(128);
    @(negedge clk);
    in_valid = 1'b0;
    #2 chk("lat_edge1", out_valid, 0);
    @(negedge clk);
    #2 chk("lat_edge2", out_valid, 0);
    @(negedge clk);
    #2;
    chk("lat_edge3", out_valid, 1);
    chk("lat_score", out_score, 128);

    // Single-bin and saturation vectors.
    send(40'h00_0000_0001, 64'h0, 127);
    send(40'h0, 64'h0100_0000_0000_0000, 136);
    send(40'h0, 64'h0000_0000_0000_0003, 128);
    send(40'h01_0000_0000, 64'h0, 127);
    send(40'h0, 64'hFF00_0000_0000_0000, 255);
    send(40'h00_0000_00FF, 64'h0, 0);
    idle();
    drain();
    clear_frame(0);

    // Frame: 130,140,140,90, rest 100 -> class 1 wins with 140.
    p0 = n_pulse;
    send(40'h0, 64'h0000_0100_0000_0000, 130);
    send(40'h0, 64'h0101_0000_0000_0000, 140);
    send(40'h0, 64'h0101_0000_0000_0000, 140);
    send(40'h00_0000_0026, 64'h0, 90);
    for (int i = 0; i < 6; i++) send(40'h00_0000_001C, 64'h0, 100);
    idle();
    drain();
    chk("frame_pulses", n_pulse - p0, 1);
    chk("frame_best_class", best_class, 1);
    chk("frame_best_score", best_score, 140);

    // Three frames under random backpressure.
    p0 = n_pulse;
    rnd_rdy = 1;
    for (int i = 0; i < 30; i++) send_rand();
    idle();
    drain();
    rnd_rdy = 0;
    repeat (2) @(negedge clk);
    chk("rand_pulses", n_pulse - p0, 3);

    // Abort after class 4, drop a beat during clear, then a full frame.
    p0 = n_pulse;
    for (int i = 0; i < 5; i++) send_rand();
    clear_frame(1);
    repeat (3) @(negedge clk);
    chk("abort_no_pulse", n_pulse - p0, 0);
    for (int i = 0; i < 10; i++) send_rand();
    idle();
    drain();
    chk("post_clear_pulses", n_pulse - p0, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pow2_score_pipe.md
# pow2_score_pipe

Parametrised successor of the fixed 13-bin score adder. Takes per-class histograms of power-of-two weight hits (one class per beat, valid/ready), computes an exact signed fixed-point score per class, saturates it to an offset-binary unsigned byte, and tracks the arg-max over a frame of `N_CLASSES` beats. Sits between the per-class bin counters and the classification result register.

## Interface
- `CNT_W`, 8: width of each bin count.
- `N_NEG`, 5: negative bins; bin i weight = −2^(NEG_TOP_EXP−i).
- `N_POS`, 8: positive bins; bin j weight = +2^(POS_BOT_EXP+j).
- `NEG_TOP_EXP`, −2: exponent of negative bin 0.
- `POS_BOT_EXP`, −6: exponent of positive bin 0.
- `FRAC_BITS`, 2: output LSB = 2^−FRAC_BITS.
- `SCORE_W`, 8: output width; zero point `ZERO` = 2^(SCORE_W−1).
- `N_CLASSES`, 10: beats per frame.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1 / `in_ready` out 1: input handshake.
- `in_neg` in N_NEG×CNT_W: negative bin counts, index 0 = largest magnitude.
- `in_pos` in N_POS×CNT_W: positive bin counts, index 0 = smallest magnitude.
- `in_clear` in 1: synchronous frame abort.
- `out_valid` out 1 / `out_ready` in 1: per-class score handshake.
- `out_score` out SCORE_W: saturated offset-binary score.
- `out_class` out clog2(N_CLASSES): class index of `out_score`.
- `best_valid` out 1: one-cycle pulse at frame end.
- `best_class` out clog2(N_CLASSES), `best_score` out SCORE_W: frame arg-max.

## Operation
- Exact sum S = Σ pos_j·2^(POS_BOT_EXP+j) − Σ neg_i·2^(NEG_TOP_EXP−i), held in two's complement with F = max(0, −min exponent) fractional bits and enough integer bits that no intermediate overflows (width derived in package, no per-stage truncation).
- Result R = floor(S·2^FRAC_BITS) + ZERO (floor toward −∞), saturated to [0, 2^SCORE_W−1].
- Pipeline stage 1: registered positive and negative partial sums; stage 2: registered saturated score; then output register.
- Global enable `en = !out_valid || out_ready`; `in_ready = en && !in_clear`. A stall freezes all stages.
- Class counter increments per input acceptance, wraps N_CLASSES−1 → 0; tag travels with the beat as `out_class`.
- Arg-max updated on each output handshake: replace if score strictly greater, or if first class of frame; ties keep lower index.
- Handshake of `out_class = N_CLASSES−1`: `best_*` updated with final winner and `best_valid` pulses the next cycle; tracker re-arms.
- `in_clear`: empties pipeline (valids to 0), resets class counter and tracker, no `best_valid`. Clear with `in_valid` high: beat dropped. Clear with stalled output: output discarded.

## Timing
- Reset values: `in_ready` 1 after reset deassertion (0 during reset), `out_valid` 0, `out_score` 0, `out_class` 0, `best_valid` 0, `best_class` 0, `best_score` 0.
- Latency: beat accepted at edge t → `out_valid` high after edge t+3 (three registers), with no stall.
- Throughput one beat/cycle while `out_ready` held high.
- `out_*` stable while `out_valid && !out_ready`.
- `best_valid` high exactly one cycle after the last-class output handshake; `best_*` held until next frame end.
- Reset mid-frame: all state cleared asynchronously; partial frame lost.

## Structure
- Package `score_pkg`: derived sum width and fractional-bit count functions, `ZERO` constant, saturate function, class index typedef.
- One sub-module `score_argmax`: frame counter of handshakes, compare/replace, `best_*` registers, `best_valid` pulse; takes handshake and `in_clear`.

## Test plan
- Default params, neg={0,0,0,0,0}, pos={0,0,0,0,0,0,0,0} → `out_score` 128 after 3 cycles.
- neg[0]=1 (−0.25), all else 0 → 127; pos[7]=1 (+2.0) → 136; pos[0]=3 (+0.046875) → 128 (floor); neg[4]=1 (−0.015625) → 127 (floor toward −∞).
- Saturation: pos[7]=255 → 255; neg[0]=255 → 0.
- Frame of 10 beats with scores 130,140,140,90,…, all others 100 → `best_class` 1, `best_score` 140, one `best_valid` pulse.
- Random `out_ready` toggling over 3 frames → no beat lost/duplicated, classes 0..9 in order, `out_*` stable during stall.
- `in_clear` after class 4 accepted, then full frame → no `best_valid` for aborted frame; next frame indexed from 0.
